// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: packed inputs and select on the
// accept side, registered word plus error flag on the output side.
interface mux_n_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 3
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] d;
  logic [SELW-1:0]    s;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   y;
  logic               err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output d, s, in_valid, out_ready,
    input  in_ready, y, err, out_valid
  );

  modport slave (
    input  d, s, in_valid, out_ready,
    output in_ready, y, err, out_valid
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N:1 select with a registered output word and a one-entry skid buffer.
// Out-of-range selects yield a zero word tagged with err.
module mux_n_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 3
) (
  input  logic         clk,
  input  logic         reset,
  mux_n_pipe_if.slave  bus
);
  localparam int SELW = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } word_t;

  state_e state_q, state_d;
  word_t  or_q, or_d;
  word_t  sk_q, sk_d;
  word_t  word;
  logic   acc;
  logic   pop;

  // Unmatched selects (s >= N) fall through as the flagged zero word.
  always_comb begin
    word.data = '0;
    word.err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (bus.s == SELW'(i)) begin
        word.data = bus.d[i*WIDTH +: WIDTH];
        word.err  = 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.y         = or_q.data;
  assign bus.err       = or_q.err;

  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          or_d    = word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          or_d = word;
        end else if (acc) begin
          sk_d    = word;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          or_d    = sk_q;
          sk_d    = '0;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
    end
  end
endmodule
